pm_resp_ctrl: RTL
=================

// Module: pm_resp_ctrl
// PURPOSE
//  Program-memory responder: the PM end of the sequencer fetch interface (ps_pm_cslt/ps_pm_wrb/ps_pm_add -> pm_ps_op).
//  Holds a 2^AW x 32 instruction store and returns one opcode per enabled read with 1-cycle registered latency.
//  A byte-stream boot loader fills the store after reset; pm_stall tells the sequencer to hold until loading is done.
// PARAMETERS
//  AW      10        word-address width; store depth = 2^AW words
//  NOP_OP  32'h0     opcode driven whenever no valid read data exists (decodes as no instruction in PS)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous, active-low reset
//  ps_pm_cslt    in   1   PM access enable from sequencer
//  ps_pm_wrb     in   1   0 = read, 1 = write
//  ps_pm_add     in   16  PM word address
//  ps_pm_wdt     in   32  write data (used when ps_pm_wrb=1)
//  pm_ps_op      out  32  fetched opcode to sequencer, registered
//  pm_stall      out  1   1 while boot loading is in progress (state != RUN)
//  boot_skip     in   1   1 = skip loading, go straight to RUN with existing contents
//  boot_vld      in   1   boot byte valid
//  boot_dt       in   8   boot byte
//  boot_rdy      out  1   boot byte accepted on clk edge when boot_vld & boot_rdy
//  pm_err        out  1   sticky error flag; cleared only by rst
// BEHAVIOUR
//  Reset values: pm_ps_op=NOP_OP, pm_err=0, state=HDR0, word/byte counters=0. The store itself is not reset.
//  boot_rdy = (state==HDR0|HDR1|DATA). pm_stall = (state!=RUN). Both are combinational from state.
//  FSM:
//   HDR0: if boot_skip -> RUN (no byte consumed); else on byte accept len[7:0]<=boot_dt -> HDR1.
//   HDR1: on byte accept len[15:8]<=boot_dt; if the 16-bit length N==0 -> RUN, else -> DATA.
//   DATA: bytes are assembled little-endian (first byte = [7:0]). On the 4th byte, the word is written to mem[waddr].
//     waddr increments; the byte counter wraps to 0. After the N-th word -> RUN.
//     Words with waddr >= 2^AW are discarded and set pm_err; the count still advances.
//   RUN: terminal until rst. Boot bytes are ignored (boot_rdy=0).
//  Read (RUN, cslt=1, wrb=0): pm_ps_op <= mem[ps_pm_add[AW-1:0]] at this edge.
//   The opcode is valid in the cycle after the address is presented.
//  ps_pm_add[15:AW] != 0 on a read: pm_ps_op <= NOP_OP and pm_err <= 1.
//  Write (RUN, cslt=1, wrb=1): mem[add] <= ps_pm_wdt; pm_ps_op <= NOP_OP.
//   An out-of-range write is dropped and sets pm_err.
//  cslt=0 in RUN: pm_ps_op <= NOP_OP (no hold of the last opcode).
//  Outside RUN: all PS accesses are ignored and pm_ps_op stays NOP_OP.
//  Write followed by a read of the same address on the next cycle: the read returns the new data (no stale read).
//  rst asserted mid-boot: FSM returns to HDR0 and counters clear; partially loaded words remain in the store.
//   A partial word assembly is discarded.
//  boot_vld low inside a word: assembly pauses with no timeout; bytes already received are kept.
// TESTING
//  1. Boot N=2, bytes 02 00 | 11 22 33 44 | AA BB CC DD -> mem[0]=32'h44332211, mem[1]=32'hDDCCBBAA.
//     pm_stall falls the cycle after the 10th byte is accepted.
//  2. RUN, cslt=1 wrb=0, addresses 0,1,2 on consecutive cycles -> pm_ps_op = mem[0],mem[1],mem[2], each one cycle later.
//  3. boot_skip=1 at reset release -> RUN next edge, no byte consumed, boot_rdy=0, pm_stall=0.
//  4. Read address 16'h0400 with AW=10 -> pm_ps_op=32'h0 and pm_err=1, which stays set through subsequent reads.
//  5. Write 32'hCAFE0001 to address 5, read address 5 next cycle -> pm_ps_op=32'hCAFE0001.
//     cslt=0 on the following cycle -> pm_ps_op=32'h0.
//  6. rst low after 6 bytes of an N=3 boot -> HDR0, mem[0] retained.
//     Re-boot with N=0 -> RUN after 2 bytes, with mem[0] unchanged.

Source files
------------

// File: rtl/pm_resp_ctrl.sv
// Program-memory responder: boot-loads a 2^AW x 32 store from a byte stream,
// then serves sequencer fetches with one cycle of registered read latency.
module pm_resp_ctrl #(
    parameter int          AW     = 10,
    parameter logic [31:0] NOP_OP = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps_pm_cslt,
    input  logic        ps_pm_wrb,
    input  logic [15:0] ps_pm_add,
    input  logic [31:0] ps_pm_wdt,
    output logic [31:0] pm_ps_op,
    output logic        pm_stall,
    input  logic        boot_skip,
    input  logic        boot_vld,
    input  logic [7:0]  boot_dt,
    output logic        boot_rdy,
    output logic        pm_err
);
    typedef enum logic [1:0] {HDR0, HDR1, DATA, RUN} state_t;

    state_t      state;
    logic [31:0] mem [0:(1<<AW)-1];
    logic [15:0] len;
    logic [15:0] waddr;
    logic [1:0]  bcnt;
    logic [23:0] asm_q;

    logic          acc, ps_rd, ps_wr, ps_oor, word_done, boot_oor, mem_we;
    logic [AW-1:0] mem_wa;
    logic [31:0]   mem_wd;

    assign boot_rdy  = (state != RUN);
    assign pm_stall  = (state != RUN);
    assign acc       = boot_vld & boot_rdy;
    assign ps_rd     = (state == RUN) & ps_pm_cslt & ~ps_pm_wrb;
    assign ps_wr     = (state == RUN) & ps_pm_cslt & ps_pm_wrb;
    assign ps_oor    = (ps_pm_add >> AW) != 16'd0;
    assign word_done = (state == DATA) & acc & (bcnt == 2'd3);
    assign boot_oor  = (waddr >> AW) != 16'd0;

    // Boot and PS writes never coincide: PS accesses only exist in RUN.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = ps_pm_add[AW-1:0];
        mem_wd = ps_pm_wdt;
        if (word_done && !boot_oor) begin
            mem_we = 1'b1;
            mem_wa = waddr[AW-1:0];
            mem_wd = {boot_dt, asm_q};
        end else if (ps_wr && !ps_oor) begin
            mem_we = 1'b1;
        end
    end

    // Store is intentionally not reset so contents survive a re-boot.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HDR0;
            len      <= 16'd0;
            waddr    <= 16'd0;
            bcnt     <= 2'd0;
            asm_q    <= 24'd0;
            pm_ps_op <= NOP_OP;
            pm_err   <= 1'b0;
        end else begin
            pm_ps_op <= NOP_OP;
            if (ps_rd && !ps_oor)
                pm_ps_op <= mem[ps_pm_add[AW-1:0]];
            if (((ps_rd || ps_wr) && ps_oor) || (word_done && boot_oor))
                pm_err <= 1'b1;

            case (state)
                HDR0: begin
                    if (boot_skip) begin
                        state <= RUN;
                    end else if (acc) begin
                        len[7:0] <= boot_dt;
                        state    <= HDR1;
                    end
                end
                HDR1: begin
                    if (acc) begin
                        len[15:8] <= boot_dt;
                        state     <= ({boot_dt, len[7:0]} == 16'd0) ? RUN : DATA;
                    end
                end
                DATA: begin
                    if (acc) begin
                        bcnt <= bcnt + 2'd1;
                        if (bcnt != 2'd3)
                            asm_q[bcnt*8 +: 8] <= boot_dt;
                        else begin
                            // Out-of-range words still count toward N.
                            waddr <= waddr + 16'd1;
                            if (waddr + 16'd1 == len)
                                state <= RUN;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
